// File: rtl/rf_scoreboard.sv
// rf_scoreboard: decode-stage issue interlock for 16 GPRs and 4 bitmap regs.
// Keeps a pending-write count per register. It stalls decode on RAW hazards
// and when a destination counter would overflow.
// Optional feature: define SB_WB_BYPASS_EN so that a writeback in the same
// cycle clears a source hazard and relaxes the overflow check.
// Ports:
//   clk, rst (async, active-high)
//   dec_* : decoded instruction (valid, sources, destinations, enables)
//   wb_*  : reg_file writeback strobes (GPR and bitmap)
//   flush : cancels all in-flight writes
//   stall, issue : combinational interlock outputs
//   pend_regs, pend_bm, busy : pending state, updated at the clock edge
//   err : sticky, set by a writeback to an entry that has no pending write
module rf_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int REG_AW   = 4,
    parameter int NUM_BM   = 4,
    parameter int BM_AW    = 2,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [REG_AW-1:0]   dec_rs1,
    input  logic                dec_rs1_en,
    input  logic [REG_AW-1:0]   dec_rs2,
    input  logic                dec_rs2_en,
    input  logic [BM_AW-1:0]    dec_rbm,
    input  logic                dec_rbm_en,
    input  logic [REG_AW-1:0]   dec_rd,
    input  logic                dec_rd_en,
    input  logic [BM_AW-1:0]    dec_wbm,
    input  logic                dec_wbm_en,
    input  logic                wb_reg_en,
    input  logic [REG_AW-1:0]   wb_reg_addr,
    input  logic                wb_bm_en,
    input  logic [BM_AW-1:0]    wb_bm_addr,
    input  logic                flush,
    output logic                stall,
    output logic                issue,
    output logic [NUM_REGS-1:0] pend_regs,
    output logic [NUM_BM-1:0]   pend_bm,
    output logic                busy,
    output logic                err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] cnt  [NUM_REGS];
    logic [CNT_W-1:0] bcnt [NUM_BM];
    logic             err_q;

    logic [CNT_W-1:0] rs1_c, rs2_c, rbm_c, rd_c, wbm_c;
    logic [NUM_REGS-1:0] r_inc, r_dec;
    logic [NUM_BM-1:0]   b_inc, b_dec;
    logic                wb_err;

    // Count as seen by the hazard check. With bypass enabled, a same-cycle
    // writeback has already retired one pending write.
    function automatic logic [CNT_W-1:0] eff(input logic [CNT_W-1:0] c,
                                             input logic hit);
`ifdef SB_WB_BYPASS_EN
        return (hit && c != '0) ? c - CNT_W'(1) : c;
`else
        return hit ? c : c;
`endif
    endfunction

    always_comb begin
        rs1_c = eff(cnt[dec_rs1], wb_reg_en && wb_reg_addr == dec_rs1);
        rs2_c = eff(cnt[dec_rs2], wb_reg_en && wb_reg_addr == dec_rs2);
        rd_c  = eff(cnt[dec_rd],  wb_reg_en && wb_reg_addr == dec_rd);
        rbm_c = eff(bcnt[dec_rbm], wb_bm_en && wb_bm_addr == dec_rbm);
        wbm_c = eff(bcnt[dec_wbm], wb_bm_en && wb_bm_addr == dec_wbm);
    end

    always_comb begin
        stall = dec_valid & (
                  (dec_rs1_en & (rs1_c != '0)) |
                  (dec_rs2_en & (rs2_c != '0)) |
                  (dec_rbm_en & (rbm_c != '0)) |
                  (dec_rd_en  & (rd_c  == MAX)) |
                  (dec_wbm_en & (wbm_c == MAX)));
        issue = dec_valid & ~stall;
    end

    always_comb begin
        r_inc = '0;
        r_dec = '0;
        b_inc = '0;
        b_dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            r_inc[i] = issue & dec_rd_en & (dec_rd == REG_AW'(i));
            r_dec[i] = wb_reg_en & (wb_reg_addr == REG_AW'(i));
        end
        for (int i = 0; i < NUM_BM; i++) begin
            b_inc[i] = issue & dec_wbm_en & (dec_wbm == BM_AW'(i));
            b_dec[i] = wb_bm_en & (wb_bm_addr == BM_AW'(i));
        end
        wb_err = (wb_reg_en & (cnt[wb_reg_addr] == '0)) |
                 (wb_bm_en  & (bcnt[wb_bm_addr] == '0));
    end

    // A writeback to an empty entry is clamped at zero and only flags err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            for (int i = 0; i < NUM_BM; i++)   bcnt[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
            for (int i = 0; i < NUM_BM; i++)   bcnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_inc[i] && !r_dec[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (!r_inc[i] && r_dec[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
            for (int i = 0; i < NUM_BM; i++) begin
                if (b_inc[i] && !b_dec[i])
                    bcnt[i] <= bcnt[i] + CNT_W'(1);
                else if (!b_inc[i] && b_dec[i] && bcnt[i] != '0)
                    bcnt[i] <= bcnt[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (wb_err)
            err_q <= 1'b1;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) pend_regs[i] = (cnt[i] != '0);
        for (int i = 0; i < NUM_BM; i++)   pend_bm[i]   = (bcnt[i] != '0);
        busy = (|pend_regs) | (|pend_bm);
        err  = err_q;
    end

endmodule

// File: tb/tb_rf_scoreboard.sv
// tb_rf_scoreboard: directed bench for rf_scoreboard.
// A count-per-register model is compared against the DUT on every falling edge.
module tb_rf_scoreboard;

`ifdef SB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic [3:0] dec_rs1;
    logic       dec_rs1_en;
    logic [3:0] dec_rs2;
    logic       dec_rs2_en;
    logic [1:0] dec_rbm;
    logic       dec_rbm_en;
    logic [3:0] dec_rd;
    logic       dec_rd_en;
    logic [1:0] dec_wbm;
    logic       dec_wbm_en;
    logic       wb_reg_en;
    logic [3:0] wb_reg_addr;
    logic       wb_bm_en;
    logic [1:0] wb_bm_addr;
    logic       flush;
    logic       stall;
    logic       issue;
    logic [15:0] pend_regs;
    logic [3:0]  pend_bm;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    int mcnt [16];
    int mbcnt [4];
    bit merr;
    int nc [16];
    int nb [4];

    rf_scoreboard dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid),
        .dec_rs1(dec_rs1), .dec_rs1_en(dec_rs1_en),
        .dec_rs2(dec_rs2), .dec_rs2_en(dec_rs2_en),
        .dec_rbm(dec_rbm), .dec_rbm_en(dec_rbm_en),
        .dec_rd(dec_rd), .dec_rd_en(dec_rd_en),
        .dec_wbm(dec_wbm), .dec_wbm_en(dec_wbm_en),
        .wb_reg_en(wb_reg_en), .wb_reg_addr(wb_reg_addr),
        .wb_bm_en(wb_bm_en), .wb_bm_addr(wb_bm_addr),
        .flush(flush),
        .stall(stall), .issue(issue),
        .pend_regs(pend_regs), .pend_bm(pend_bm),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Pending count as the hazard rule sees it.
    function automatic int seen(input int c, input bit hit);
        if (BYP && hit && c > 0) return c - 1;
        return c;
    endfunction

    function automatic bit m_stall();
        bit s;
        s = 1'b0;
        if (!dec_valid) return 1'b0;
        if (dec_rs1_en &&
            seen(mcnt[dec_rs1], wb_reg_en && wb_reg_addr == dec_rs1) > 0)
            s = 1'b1;
        if (dec_rs2_en &&
            seen(mcnt[dec_rs2], wb_reg_en && wb_reg_addr == dec_rs2) > 0)
            s = 1'b1;
        if (dec_rbm_en &&
            seen(mbcnt[dec_rbm], wb_bm_en && wb_bm_addr == dec_rbm) > 0)
            s = 1'b1;
        if (dec_rd_en &&
            seen(mcnt[dec_rd], wb_reg_en && wb_reg_addr == dec_rd) == 3)
            s = 1'b1;
        if (dec_wbm_en &&
            seen(mbcnt[dec_wbm], wb_bm_en && wb_bm_addr == dec_wbm) == 3)
            s = 1'b1;
        return s;
    endfunction

    function automatic logic [15:0] m_pend();
        logic [15:0] p;
        for (int i = 0; i < 16; i++) p[i] = (mcnt[i] != 0);
        return p;
    endfunction

    function automatic logic [3:0] m_pbm();
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = (mbcnt[i] != 0);
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mcnt[i] <= 0;
            for (int i = 0; i < 4; i++)  mbcnt[i] <= 0;
            merr <= 1'b0;
        end else begin
            bit iss;
            iss = dec_valid && !m_stall();
            if ((wb_reg_en && mcnt[wb_reg_addr] == 0) ||
                (wb_bm_en && mbcnt[wb_bm_addr] == 0))
                merr <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                nc[i] = mcnt[i];
                if (iss && dec_rd_en && dec_rd == 4'(i)) nc[i] = nc[i] + 1;
                if (wb_reg_en && wb_reg_addr == 4'(i)) nc[i] = nc[i] - 1;
                if (nc[i] < 0) nc[i] = 0;
                if (flush) nc[i] = 0;
                mcnt[i] <= nc[i];
            end
            for (int i = 0; i < 4; i++) begin
                nb[i] = mbcnt[i];
                if (iss && dec_wbm_en && dec_wbm == 2'(i)) nb[i] = nb[i] + 1;
                if (wb_bm_en && wb_bm_addr == 2'(i)) nb[i] = nb[i] - 1;
                if (nb[i] < 0) nb[i] = 0;
                if (flush) nb[i] = 0;
                mbcnt[i] <= nb[i];
            end
        end
    end

    always @(negedge clk) begin
        chk("m_stall", 32'(stall), 32'(m_stall()));
        chk("m_issue", 32'(issue), 32'(dec_valid && !m_stall()));
        chk("m_pend_regs", 32'(pend_regs), 32'(m_pend()));
        chk("m_pend_bm", 32'(pend_bm), 32'(m_pbm()));
        chk("m_busy", 32'(busy), 32'(|{m_pend(), m_pbm()}));
        chk("m_err", 32'(err), 32'(merr));
    end

    task automatic clr();
        dec_valid = 0; dec_rs1 = 0; dec_rs1_en = 0;
        dec_rs2 = 0; dec_rs2_en = 0; dec_rbm = 0; dec_rbm_en = 0;
        dec_rd = 0; dec_rd_en = 0; dec_wbm = 0; dec_wbm_en = 0;
        wb_reg_en = 0; wb_reg_addr = 0; wb_bm_en = 0; wb_bm_addr = 0;
        flush = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic wr(input int rd);
        dec_valid = 1; dec_rd_en = 1; dec_rd = 4'(rd);
    endtask

    initial begin
        rst = 1'b1;
        clr();
        tick();
        tick();
        @(negedge clk);
        chk("rst_pend_regs", 32'(pend_regs), 0);
        chk("rst_pend_bm", 32'(pend_bm), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_stall", 32'(stall), 0);
        rst = 1'b0;
        tick();

        wr(5);
        @(negedge clk);
        chk("raw_issue_rd5", 32'(issue), 1);
        tick();
        dec_valid = 1; dec_rs1_en = 1; dec_rs1 = 5;
        @(negedge clk);
        chk("raw_stall", 32'(stall), 1);
        chk("raw_pend5", 32'(pend_regs), 32'h0020);
        tick();
        dec_valid = 1; dec_rs1_en = 1; dec_rs1 = 5;
        wb_reg_en = 1; wb_reg_addr = 5;
        @(negedge clk);
        chk("raw_wb_stall", 32'(stall), 32'(!BYP));
        tick();
        dec_valid = 1; dec_rs1_en = 1; dec_rs1 = 5;
        @(negedge clk);
        chk("raw_after_issue", 32'(issue), 1);
        chk("raw_after_pend", 32'(pend_regs), 0);
        tick();

        for (int k = 0; k < 3; k++) begin
            wr(3);
            @(negedge clk);
            chk("ovf_issue", 32'(issue), 1);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            wr(3);
            @(negedge clk);
            chk("ovf_stall", 32'(stall), 1);
            chk("ovf_pend3", 32'(pend_regs), 32'h0008);
            tick();
        end
        wr(3);
        wb_reg_en = 1; wb_reg_addr = 3;
        @(negedge clk);
        chk("ovf_wb_stall", 32'(stall), 32'(!BYP));
        tick();
        if (!BYP) begin
            wr(3);
            @(negedge clk);
            chk("ovf_late_issue", 32'(issue), 1);
            tick();
        end
        flush = 1;
        tick();
        @(negedge clk);
        chk("ovf_flush_pend", 32'(pend_regs), 0);
        chk("ovf_flush_busy", 32'(busy), 0);
        tick();

        wr(7);
        tick();
        wr(7);
        wb_reg_en = 1; wb_reg_addr = 7;
        @(negedge clk);
        chk("sim_issue", 32'(issue), 1);
        tick();
        wb_reg_en = 1; wb_reg_addr = 7;
        @(negedge clk);
        chk("sim_pend7", 32'(pend_regs), 32'h0080);
        tick();
        dec_valid = 1; dec_wbm_en = 1; dec_wbm = 2;
        @(negedge clk);
        chk("bm_pend7_clear", 32'(pend_regs), 0);
        chk("bm_issue", 32'(issue), 1);
        tick();
        dec_valid = 1; dec_rbm_en = 1; dec_rbm = 2;
        @(negedge clk);
        chk("bm_stall", 32'(stall), 1);
        chk("bm_pend2", 32'(pend_bm), 4'b0100);
        tick();
        dec_valid = 1; dec_rbm_en = 1; dec_rbm = 2;
        wb_bm_en = 1; wb_bm_addr = 2;
        @(negedge clk);
        chk("bm_wb_stall", 32'(stall), 32'(!BYP));
        tick();
        dec_valid = 1; dec_rbm_en = 1; dec_rbm = 2;
        @(negedge clk);
        chk("bm_late_issue", 32'(issue), 1);
        chk("bm_pend_clear", 32'(pend_bm), 0);
        tick();

        wr(1);
        tick();
        wr(4);
        dec_wbm_en = 1; dec_wbm = 0;
        tick();
        wr(2);
        flush = 1;
        @(negedge clk);
        chk("fl_pend_regs", 32'(pend_regs), 32'h0012);
        chk("fl_pend_bm", 32'(pend_bm), 4'b0001);
        chk("fl_busy", 32'(busy), 1);
        chk("fl_issue", 32'(issue), 1);
        tick();
        wb_reg_en = 1; wb_reg_addr = 9;
        @(negedge clk);
        chk("fl_after_pend", 32'(pend_regs), 0);
        chk("fl_after_bm", 32'(pend_bm), 0);
        chk("fl_after_busy", 32'(busy), 0);
        chk("fl_err0", 32'(err), 0);
        tick();
        @(negedge clk);
        chk("err_set", 32'(err), 1);
        chk("err_cnt0", 32'(pend_regs), 0);
        tick();

        wr(6);
        dec_wbm_en = 1; dec_wbm = 1;
        tick();
        tick();
        chk("ar_pend_regs_pre", 32'(pend_regs), 32'h0040);
        chk("ar_pend_bm_pre", 32'(pend_bm), 4'b0010);
        chk("ar_err_pre", 32'(err), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_pend_regs", 32'(pend_regs), 0);
        chk("ar_pend_bm", 32'(pend_bm), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_err", 32'(err), 0);
        tick();
        rst = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
